// File: rtl/elevator_call_scheduler.sv
// LOOK-policy elevator scheduler: latches hall/car calls, issues move and door commands over req/ack.
// Optional idle park-to-home behaviour is compiled in with `define HOME_RETURN_EN.
module elevator_call_scheduler #(
   parameter int N_FLOORS   = 8,
   parameter int FLOOR_W    = 4,
   parameter int HOME_FLOOR = 0,
   parameter int HOME_TICKS = 10
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                tick,
   input  logic [N_FLOORS-1:0] up_call,
   input  logic [N_FLOORS-1:0] down_call,
   input  logic [N_FLOORS-1:0] car_call,
   output logic                move_req,
   output logic                move_dir,
   input  logic                move_ack,
   output logic                door_req,
   input  logic                door_done,
   output logic [FLOOR_W-1:0]  floor,
   output logic                dir_up,
   output logic                dir_down,
   output logic [N_FLOORS-1:0] pend_up,
   output logic [N_FLOORS-1:0] pend_down,
   output logic [N_FLOORS-1:0] pend_car,
   output logic                busy
);

   typedef enum logic [1:0] {S_IDLE, S_DECIDE, S_MOVE, S_DOOR} state_t;

   state_t              state, state_nxt;
   logic                dir_up_nxt, dir_down_nxt, move_dir_nxt, door_entry;
   logic [N_FLOORS-1:0] fbit, below_mask, above_mask, all_pend;
   logic [N_FLOORS-1:0] absorb, up_in, down_in, car_in, home_bit;
   logic [N_FLOORS-1:0] clr_up, clr_down, clr_car;
   logic                here_car, here_up, here_down, req_above, req_below;

   assign fbit       = N_FLOORS'(1) << floor;
   assign below_mask = fbit - N_FLOORS'(1);
   assign above_mask = ~(below_mask | fbit);
   assign all_pend   = pend_up | pend_down | pend_car;

   // Calls at the current floor are swallowed while the door is cycling there.
   assign absorb  = (state == S_DOOR) ? fbit : '0;
   assign up_in   = up_call & ~absorb & ~(N_FLOORS'(1) << (N_FLOORS - 1));
   assign down_in = down_call & ~absorb & ~N_FLOORS'(1);
   assign car_in  = (car_call | home_bit) & ~absorb;

   assign here_car  = |(pend_car & fbit);
   assign here_up   = |(pend_up & fbit);
   assign here_down = |(pend_down & fbit);
   assign req_above = |(all_pend & above_mask);
   assign req_below = |(all_pend & below_mask);

   assign move_req = (state == S_MOVE);
   assign door_req = (state == S_DOOR);
   assign busy     = (state != S_IDLE);

   always_comb begin
      state_nxt    = state;
      dir_up_nxt   = dir_up;
      dir_down_nxt = dir_down;
      move_dir_nxt = move_dir;
      door_entry   = 1'b0;
      unique case (state)
         S_IDLE: begin
            dir_up_nxt   = 1'b0;
            dir_down_nxt = 1'b0;
            if (|(all_pend | up_in | down_in | car_in))
               state_nxt = S_DECIDE;
         end
         S_DECIDE: begin
            if (here_car || (dir_up && here_up) || (dir_down && here_down) ||
                (!dir_up && !dir_down && (here_up || here_down))) begin
               door_entry = 1'b1;
            end else if (dir_up && req_above) begin
               state_nxt    = S_MOVE;
               move_dir_nxt = 1'b1;
            end else if (dir_down && req_below) begin
               state_nxt    = S_MOVE;
               move_dir_nxt = 1'b0;
            end else if (dir_up && here_down) begin
               dir_up_nxt   = 1'b0;
               dir_down_nxt = 1'b1;
               door_entry   = 1'b1;
            end else if (dir_down && here_up) begin
               dir_up_nxt   = 1'b1;
               dir_down_nxt = 1'b0;
               door_entry   = 1'b1;
            // Nothing ahead: reverse, or pick a fresh direction preferring up.
            end else if (req_above) begin
               state_nxt    = S_MOVE;
               move_dir_nxt = 1'b1;
               dir_up_nxt   = 1'b1;
               dir_down_nxt = 1'b0;
            end else if (req_below) begin
               state_nxt    = S_MOVE;
               move_dir_nxt = 1'b0;
               dir_up_nxt   = 1'b0;
               dir_down_nxt = 1'b1;
            end else begin
               state_nxt = S_IDLE;
            end
            if (door_entry)
               state_nxt = S_DOOR;
         end
         S_MOVE: begin
            if (move_ack)
               state_nxt = S_DECIDE;
         end
         S_DOOR: begin
            if (door_done)
               state_nxt = S_DECIDE;
         end
      endcase
   end

   // With no committed direction both hall calls at the floor are served.
   assign clr_car  = door_entry ? fbit : '0;
   assign clr_up   = (door_entry && (dir_up_nxt || !dir_down_nxt)) ? fbit : '0;
   assign clr_down = (door_entry && (dir_down_nxt || !dir_up_nxt)) ? fbit : '0;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= S_IDLE;
         floor     <= '0;
         dir_up    <= 1'b0;
         dir_down  <= 1'b0;
         move_dir  <= 1'b0;
         pend_up   <= '0;
         pend_down <= '0;
         pend_car  <= '0;
      end else begin
         state     <= state_nxt;
         dir_up    <= dir_up_nxt;
         dir_down  <= dir_down_nxt;
         move_dir  <= move_dir_nxt;
         pend_up   <= (pend_up | up_in) & ~clr_up;
         pend_down <= (pend_down | down_in) & ~clr_down;
         pend_car  <= (pend_car | car_in) & ~clr_car;
         if (state == S_MOVE && move_ack) begin
            if (move_dir && floor != FLOOR_W'(N_FLOORS - 1))
               floor <= floor + FLOOR_W'(1);
            else if (!move_dir && floor != '0)
               floor <= floor - FLOOR_W'(1);
         end
      end
   end

`ifdef HOME_RETURN_EN
   localparam int CNT_W = $clog2(HOME_TICKS + 1);

   logic [CNT_W-1:0] home_cnt;
   logic             home_hit;

   assign home_hit = (home_cnt == CNT_W'(HOME_TICKS));
   assign home_bit = home_hit ? (N_FLOORS'(1) << HOME_FLOOR) : '0;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         home_cnt <= '0;
      else if (state != S_IDLE || (|all_pend) || floor == FLOOR_W'(HOME_FLOOR))
         home_cnt <= '0;
      else if (tick && !home_hit)
         home_cnt <= home_cnt + CNT_W'(1);
   end
`else
   assign home_bit = '0;
`endif

endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
Request scheduler between the input processor and the car motion/door unit. Latches hall up/down calls and in-car floor buttons, tracks car position and travel direction, and picks the next action using a LOOK policy: continue in the current direction while requests remain ahead, otherwise reverse or idle. Issues one-at-a-time move and door commands over req/ack handshakes. Exports pending-request bitmaps and status to the display.

Parameters:
N_FLOORS, 8, number of floors, indexed 0..N_FLOORS-1
FLOOR_W, 4, width of floor index
HOME_FLOOR, 0, idle park floor (optional feature only)
HOME_TICKS, 10, idle tick count before parking (optional feature only)

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous reset, active-high
tick  input  1  one-cycle 1 s enable pulse, from the 1 s clock divider
up_call  input  N_FLOORS  hall up buttons, level, sampled every cycle
down_call  input  N_FLOORS  hall down buttons, level, sampled every cycle
car_call  input  N_FLOORS  in-car floor buttons, level
move_req  output  1  request motion unit to move one floor
move_dir  output  1  1=up, 0=down; valid while move_req=1
move_ack  input  1  one-cycle pulse: one floor traversed
door_req  output  1  request door open/dwell/close cycle
door_done  input  1  one-cycle pulse: door cycle complete
floor  output  FLOOR_W  current car floor
dir_up  output  1  committed direction is up
dir_down  output  1  committed direction is down
pend_up  output  N_FLOORS  latched up-call bitmap
pend_down  output  N_FLOORS  latched down-call bitmap
pend_car  output  N_FLOORS  latched car-call bitmap
busy  output  1  state is not IDLE

Behaviour:
- Reset (async, RST=1): state IDLE, floor=0, dir_up=dir_down=0, all pend_* = 0, move_req=door_req=0, busy=0.
- Latching: pend_x[i] |= x_call[i] every cycle. Ignore up_call[N_FLOORS-1] and down_call[0] (bits forced to 0).
- States: IDLE, DECIDE, MOVE, DOOR.
- IDLE: if any pend bit is set, go to DECIDE next cycle. Otherwise clear dir_up and dir_down.
- DECIDE (one cycle), evaluated on the current floor f:
  a) Serve here: if pend_car[f] is set, or the hall call at f matches the current direction, or no direction is set and any hall call at f is set, go to DOOR.
  b) Continue: else if there is a request strictly ahead in the current direction, go to MOVE in that direction.
  c) Reverse: else if there is a request behind, flip direction and go to MOVE. A hall call at f in the opposite direction counts as "here": set the flipped direction and go to DOOR.
  d) Idle: else go to IDLE.
  e) With no direction set, prefer up if any request is above; otherwise go down.
- MOVE: hold move_req=1 and move_dir stable until move_ack. On move_ack, floor updates by ±1 in the same cycle and state returns to DECIDE. floor saturates at 0 and N_FLOORS-1 and never wraps; the scheduler never issues a move past either end.
- DOOR: on entry, clear pend_car[f] and the pend hall bit for the served direction. If the direction became none, clear both hall bits at f. Hold door_req=1 until door_done, then go to DECIDE.
- New calls for the current floor that arrive while in DOOR are absorbed (not latched). The same applies on the DOOR entry cycle: clear wins over set.
- move_ack outside MOVE and door_done outside DOOR are ignored.
- Output latency: outputs are registered; move_req/door_req assert the cycle after entering MOVE/DOOR.
- Worst-case decision latency from a first call in IDLE to a command: 2 cycles.
- Reset mid-MOVE or mid-DOOR drops the request immediately; the motion unit must tolerate req removal.

Optional Feature:
- Macro: HOME_RETURN_EN.
- Defined: in IDLE with floor != HOME_FLOOR, count tick pulses; any pend bit set resets the count. When the count reaches HOME_TICKS, set pend_car[HOME_FLOOR]. The counter is cleared on leaving IDLE and on RST.
- Undefined: the car parks wherever it last stopped; no counter logic is present.

Test Plan:
- Reset, then car_call[3] pulse at floor 0 → move_req, move_dir=1, three ack pulses → floor=3, door_req=1, pend_car=0 after door_done, returns to IDLE.
- At floor 2 going up, pend car[5] and up[4] and down[1] → stops at 4 then 5, reverses, stops at 1; dir_down=1 on the final leg.
- At floor 3 idle, down_call[3] pressed → door_req within 2 cycles, no move_req, pend_down[3] cleared.
- Press up_call[7] and down_call[0] → neither bit latches; pend_up=pend_down=0, state stays IDLE.
- Assert RST for one cycle during MOVE at floor 4 → move_req=0 and floor=0 immediately; later move_ack ignored.
- HOME_RETURN_EN defined, idle at floor 5, 10 tick pulses → pend_car[0] set, car travels to 0. Undefined → car stays at 5.
